// File: rtl/gpu_pixel_writer.sv
// gpu_pixel_writer: end of the pixel stream from the rasteriser and fill engines.
// On-screen pixels are converted to a linear framebuffer address and held in a
// small FIFO. Each one becomes a single SRAM write over a req/ack handshake.
// Off-screen pixels are dropped, and each drop is reported with a one-cycle pulse.
module gpu_pixel_writer #(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int ADDR_BITS    = 19,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      px_valid_i,
    output logic                      px_ready_o,
    input  logic [WIDTH_BITS-1:0]     x_i,
    input  logic [HEIGHT_BITS-1:0]    y_i,
    input  logic [CHANNEL_BITS-1:0]   r_i,
    input  logic [CHANNEL_BITS-1:0]   g_i,
    input  logic [CHANNEL_BITS-1:0]   b_i,
    output logic                      mem_req_o,
    output logic [ADDR_BITS-1:0]      mem_addr_o,
    output logic [3*CHANNEL_BITS-1:0] mem_data_o,
    input  logic                      mem_ack_i,
    output logic                      clipped_o,
    output logic                      busy_o
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int DATA_BITS = 3 * CHANNEL_BITS;

    // One extra bit on each limit lets a screen dimension equal 2**bits.
    localparam logic [WIDTH_BITS:0]  SCREEN_W_L = (WIDTH_BITS+1)'(SCREEN_W);
    localparam logic [HEIGHT_BITS:0] SCREEN_H_L = (HEIGHT_BITS+1)'(SCREEN_H);
    localparam logic [CNT_W-1:0]     DEPTH_L    = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_BITS-1:0]   fifo_addr [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_nxt;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   on_screen;
    logic                   xfer;
    logic                   push;
    logic                   pop;

    // Linear framebuffer address for a pixel, row-major.
    function automatic logic [ADDR_BITS-1:0] pixel_addr(
        input logic [WIDTH_BITS-1:0]  x,
        input logic [HEIGHT_BITS-1:0] y
    );
        return ADDR_BITS'(y) * ADDR_BITS'(SCREEN_W) + ADDR_BITS'(x);
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_L);
    // Ready depends only on the registered count. It is also forced low while reset is held.
    assign px_ready_o = n_rst & ~fifo_full;

    assign on_screen = ({1'b0, x_i} < SCREEN_W_L) && ({1'b0, y_i} < SCREEN_H_L);
    assign xfer      = px_valid_i & px_ready_o;
    assign push      = xfer & on_screen;

    // Pop decision, next FSM state and next occupancy.
    always_comb begin
        pop       = 1'b0;
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                pop       = ~fifo_empty;
                state_nxt = fifo_empty ? IDLE : WRITE;
            end
            WRITE: begin
                pop = mem_ack_i & ~fifo_empty;
                if (mem_ack_i && fifo_empty) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO storage holds data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= pixel_addr(x_i, y_i);
            fifo_data[wr_ptr] <= {r_i, g_i, b_i};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    // Clip pulse: the transfer just taken was off-screen.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clipped_o <= 1'b0;
        end else begin
            clipped_o <= xfer & ~on_screen;
        end
    end

    // Write FSM with registered request, address, data and busy.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            busy_o     <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_req_o <= (state_nxt == WRITE);
            busy_o    <= (state_nxt == WRITE) | (count_nxt != '0);
            if (pop) begin
                mem_addr_o <= fifo_addr[rd_ptr];
                mem_data_o <= fifo_data[rd_ptr];
            end
        end
    end

endmodule
